ysyx_22050710_trap_ctrl: RTL

YSYX_22050710_TRAP_CTRL -- requirements
Module: ysyx_22050710_trap_ctrl

---
 rtl/ysyx_22050710_trap_pkg.sv | 27 ++
 rtl/ysyx_22050710_trap_csr_upd.sv | 40 ++++
 rtl/ysyx_22050710_trap_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ysyx_22050710_trap_pkg.sv
// Trap controller shared types: FSM states, trap kinds, mcause codes.
// mstatus bit positions used by the CSR update logic.
package ysyx_22050710_trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CSR,
    ST_REDIR
  } trap_st_e;

  typedef enum logic [1:0] {
    K_NONE,
    K_ECALL,
    K_MRET,
    K_IRQ
  } trap_kind_e;

  localparam int MCAUSE_ECALL_M = 11;
  localparam int MCAUSE_MTI     = 7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/ysyx_22050710_trap_csr_upd.sv
// Next-value computation for mstatus and mcause on trap entry or mret.
// Purely combinational; the controller decides when the result is written.
module ysyx_22050710_trap_csr_upd
  import ysyx_22050710_trap_pkg::*;
#(
  parameter int CSR_WD = 64
) (
  input  trap_kind_e        kind,
  input  logic [CSR_WD-1:0] mstatus,
  output logic [CSR_WD-1:0] mstatus_nxt,
  output logic [CSR_WD-1:0] mcause
);

  always_comb begin
    mstatus_nxt = mstatus;
    mcause      = '0;
    unique case (1'b1)
      kind == K_MRET: begin
        mstatus_nxt[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
        mstatus_nxt[MSTATUS_MPIE] = 1'b1;
        mstatus_nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      kind == K_ECALL: begin
        mstatus_nxt[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
        mstatus_nxt[MSTATUS_MIE]  = 1'b0;
        mstatus_nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mcause = CSR_WD'(MCAUSE_ECALL_M);
      end
      kind == K_IRQ: begin
        mstatus_nxt[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
        mstatus_nxt[MSTATUS_MIE]  = 1'b0;
        mstatus_nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mcause = CSR_WD'(MCAUSE_MTI);
        mcause[CSR_WD-1] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22050710_trap_ctrl.sv
// Trap sequencer: drain pipeline, write CSRs, redirect fetch.
// Timer interrupt entry enabled by YSYX_22050710_TRAP_IRQ_EN.
module ysyx_22050710_trap_ctrl
  import ysyx_22050710_trap_pkg::*;
#(
  parameter int CSR_WD = 64,
  parameter int PC_WD  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ecall_req,
  input  logic              i_mret_req,
  input  logic [PC_WD-1:0]  i_pc,
  input  logic              i_drain_done,
  input  logic [CSR_WD-1:0] i_mtvec,
  input  logic [CSR_WD-1:0] i_mepc,
  input  logic [CSR_WD-1:0] i_mstatus,
  input  logic              i_mtip,
  input  logic              i_mtie,
  output logic              o_busy,
  output logic              o_flush,
  output logic [2:0]        o_csr_we,
  output logic [CSR_WD-1:0] o_csr_mepc,
  output logic [CSR_WD-1:0] o_csr_mcause,
  output logic [CSR_WD-1:0] o_csr_mstatus,
  output logic              o_redirect_valid,
  input  logic              i_redirect_ready,
  output logic [PC_WD-1:0]  o_redirect_pc
);

  trap_st_e          st_q, st_d;
  trap_kind_e        kind_q, kind_d;
  logic [PC_WD-1:0]  pc_q, pc_d;
  logic [PC_WD-1:0]  rpc_q, rpc_d;
  logic              irq;
  logic [CSR_WD-1:0] mstatus_nxt;
  logic [CSR_WD-1:0] mcause_nxt;
  logic              unused;

`ifdef YSYX_22050710_TRAP_IRQ_EN
  assign irq = i_mtip & i_mtie & i_mstatus[MSTATUS_MIE];
`else
  assign irq = 1'b0;
`endif

  assign unused = ^{i_mtip, i_mtie, i_mtvec[1:0]};

  ysyx_22050710_trap_csr_upd #(
    .CSR_WD(CSR_WD)
  ) u_csr_upd (
    .kind       (kind_q),
    .mstatus    (i_mstatus),
    .mstatus_nxt(mstatus_nxt),
    .mcause     (mcause_nxt)
  );

  always_comb begin
    st_d             = st_q;
    kind_d           = kind_q;
    pc_d             = pc_q;
    rpc_d            = rpc_q;
    o_busy           = (st_q != ST_IDLE);
    o_flush          = 1'b0;
    o_csr_we         = 3'b000;
    o_csr_mepc       = '0;
    o_csr_mcause     = '0;
    o_csr_mstatus    = '0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    unique case (st_q)
      ST_IDLE: begin
        if (irq | i_ecall_req | i_mret_req) begin
          st_d   = ST_DRAIN;
          pc_d   = i_pc;
          kind_d = irq         ? K_IRQ   :
                   i_ecall_req ? K_ECALL : K_MRET;
        end
      end
      ST_DRAIN: begin
        o_flush = 1'b1;
        if (i_drain_done) st_d = ST_CSR;
      end
      ST_CSR: begin
        o_flush       = 1'b1;
        o_csr_mstatus = mstatus_nxt;
        st_d          = ST_REDIR;
        if (kind_q == K_MRET) begin
          o_csr_we = 3'b100;
          rpc_d    = i_mepc[PC_WD-1:0];
        end else begin
          o_csr_we     = 3'b111;
          o_csr_mcause = mcause_nxt;
          o_csr_mepc   = CSR_WD'(pc_q);
          rpc_d        = {i_mtvec[PC_WD-1:2], 2'b00};
        end
      end
      ST_REDIR: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = rpc_q;
        if (i_redirect_ready) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= ST_IDLE;
      kind_q <= K_NONE;
      pc_q   <= '0;
      rpc_q  <= '0;
    end else begin
      st_q   <= st_d;
      kind_q <= kind_d;
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
    end
  end

endmodule
